tst_pattern_ctrl: RTL and testbench

- Sequencer for the 8-bit test-pattern output bus (pins o0..o7) used to check the sync/link path.
- Arms on a start command and waits for an external sync pulse. It then emits a burst of exactly burst_len pattern words, one per clock, in a selectable mode, and reports completion.
- Sits between the control register interface and the output pins; replaces the free-running pattern counter with a gated, length-controlled burst.

---
 rtl/tst_pattern_ctrl_if.sv | 27 ++
 rtl/tst_pattern_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tst_pattern_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tst_pattern_ctrl_if.sv
// Control and pattern-bus bundle for the test-pattern sequencer.
// master drives the command/config side, slave is the sequencer itself.
interface tst_pattern_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             sync_in;
  logic [1:0]       mode;
  logic [CNT_W-1:0] burst_len;
  logic [7:0]       fixed_word;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, sync_in, mode, burst_len, fixed_word,
    input  o_data, o_valid, busy, done, err
  );

  modport slave (
    input  start, stop, sync_in, mode, burst_len, fixed_word,
    output o_data, o_valid, busy, done, err
  );
endinterface

// File: rtl/tst_pattern_ctrl.sv
// Test-pattern burst sequencer: arms on start, launches on a sync rising
// edge, emits burst_len words in the latched mode, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; zero-length start gives an err pulse
// ARM   | waiting for a fresh sync rising edge; timeout gives err
// RUN   | one pattern word per cycle until the last word or stop
// DONE  | one cycle to issue the done pulse
//
// All outputs are registered and reflect the state of the previous cycle,
// so o_valid/done/busy lag the internal state by one clock.
module tst_pattern_ctrl #(
  parameter int ARM_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  tst_pattern_ctrl_if.slave bus
);

  localparam int TMO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             sync_d;
  logic             sync_rise;
  logic             start_ok;
  logic             start_zero;
  logic             last_word;
  logic             tmo_hit;

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] len_q;
  logic [7:0]       fw_q;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] wc;
  logic [7:0]       walk;
  logic [TMO_W-1:0] tmo;

  logic [7:0]       data_q,  data_nxt;
  logic             valid_q, valid_nxt;
  logic             busy_q,  busy_nxt;
  logic             done_q,  done_nxt;
  logic             err_q,   err_nxt;

  assign sync_rise  = bus.sync_in & ~sync_d;
  assign start_ok   = bus.start & (bus.burst_len != '0);
  assign start_zero = bus.start & (bus.burst_len == '0);
  assign last_word  = (wc == len_q - CNT_W'(1));
  assign tmo_hit    = (tmo == '0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; stop has priority over sync and over the last word
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_ARM;
      S_ARM: begin
        if (bus.stop)      state_nxt = S_IDLE;
        else if (sync_rise) state_nxt = S_RUN;
        else if (tmo_hit)  state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (bus.stop)      state_nxt = S_IDLE;
        else if (last_word) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // next values of the registered outputs, derived from the current state
  always_comb begin
    data_nxt  = data_q;
    valid_nxt = (state == S_RUN);
    busy_nxt  = (state != S_IDLE);
    done_nxt  = (state == S_DONE);
    err_nxt   = ((state == S_IDLE) && start_zero) ||
                ((state == S_ARM) && !bus.stop && !sync_rise && tmo_hit);
    if (state == S_RUN) begin
      case (mode_q)
        2'd0:    data_nxt = pc[7:0];
        2'd1:    data_nxt = 8'(pc >> 8);
        2'd2:    data_nxt = walk;
        default: data_nxt = fw_q;
      endcase
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // sync delay, parameter latch, arm timeout down-counter and pattern counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d <= 1'b0;
      mode_q <= 2'd0;
      len_q  <= '0;
      fw_q   <= 8'h00;
      pc     <= '0;
      wc     <= '0;
      walk   <= 8'h00;
      tmo    <= '0;
    end else begin
      sync_d <= bus.sync_in;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mode_q <= bus.mode;
            len_q  <= bus.burst_len;
            fw_q   <= bus.fixed_word;
            tmo    <= TMO_LOAD;
          end
        end
        S_ARM: begin
          if (sync_rise) begin
            pc   <= '0;
            wc   <= '0;
            walk <= 8'h01;
          end else if (!tmo_hit) begin
            tmo <= tmo - TMO_W'(1);
          end
        end
        S_RUN: begin
          pc   <= pc + CNT_W'(1);
          wc   <= wc + CNT_W'(1);
          walk <= {walk[6:0], walk[7]};
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_tst_pattern_ctrl.sv
// Directed bench for tst_pattern_ctrl: cycle table plus burst/corner sequences.
module tb_tst_pattern_ctrl;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miss_cnt;

  tst_pattern_ctrl_if #(.CNT_W(16)) bus ();

  tst_pattern_ctrl #(.ARM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic        sync_in;
    logic [1:0]  mode;
    logic [15:0] len;
    logic [7:0]  fw;
    logic [7:0]  e_data;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl [21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [1:0] m, input int i, input logic [7:0] fw);
    logic [15:0] iv;
    iv = i[15:0];
    case (m)
      2'd0:    return iv[7:0];
      2'd1:    return iv[15:8];
      2'd2:    return 8'h01 << iv[2:0];
      default: return fw;
    endcase
  endfunction

  // start, wait two ARM cycles, raise sync, then collect words and done
  task automatic burst(input logic [1:0] m, input logic [15:0] len, input logic [7:0] fw, input bit inj);
    int nwords, ndone, nerr, first_valid, last_valid, done_at;
    bus.mode = m; bus.burst_len = len; bus.fixed_word = fw; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    nwords = 0; ndone = 0; nerr = 0; first_valid = -1; last_valid = -1; done_at = -1;
    for (int c = 0; c < int'(len) + 4; c++) begin
      if (inj && c == 2) begin
        bus.start = 1'b1; bus.mode = ~m; bus.burst_len = 16'd3; bus.fixed_word = ~fw;
      end
      tick();
      bus.start = 1'b0;
      if (bus.o_valid) begin
        check("burst_word", 32'(bus.o_data), 32'(exp_word(m, nwords, fw)));
        if (first_valid < 0) first_valid = c;
        nwords++;
        last_valid = c;
      end
      if (bus.done) begin ndone++; done_at = c; end
      if (bus.err) nerr++;
    end
    check("burst_first_latency", 32'(first_valid), 32'd0);
    check("burst_word_count", 32'(nwords), 32'(len));
    check("burst_done_count", 32'(ndone), 32'd1);
    check("burst_done_pos", 32'(done_at), 32'(last_valid + 1));
    check("burst_err", 32'(nerr), 32'd0);
    check("burst_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int nv, nd, ne;
    logic [7:0] last_data;
    vec_cnt  = 0;
    miss_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.sync_in = 1'b0;
    bus.mode = 2'd0; bus.burst_len = 16'd0; bus.fixed_word = 8'h00;

    //          rst   start stop  sync  mode  len     fw      data   vld   busy  done  err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'd2, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'd2, 8'h5A, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 16'd2, 8'hA5, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd7, 8'h3C, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd7, 8'h3C, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd7, 8'h3C, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd7, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd7, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd7, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd7, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};

    tick();
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst;
      bus.start = tbl[i].start; bus.stop = tbl[i].stop; bus.sync_in = tbl[i].sync_in;
      bus.mode = tbl[i].mode; bus.burst_len = tbl[i].len; bus.fixed_word = tbl[i].fw;
      tick();
      check($sformatf("tbl%0d_data", i),  32'(bus.o_data),  32'(tbl[i].e_data));
      check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_busy", i),  32'(bus.busy),    32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i),  32'(bus.done),    32'(tbl[i].e_done));
      check($sformatf("tbl%0d_err", i),   32'(bus.err),     32'(tbl[i].e_err));
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.sync_in = 1'b0;
    tick();

    burst(2'd1, 16'd300, 8'h00, 1'b0);
    burst(2'd2, 16'd10,  8'h00, 1'b1);
    burst(2'd3, 16'd2,   8'hA5, 1'b0);
    burst(2'd0, 16'd1,   8'h00, 1'b0);
    burst(2'd0, 16'd260, 8'h00, 1'b0);

    // ARM timeout with no sync
    bus.mode = 2'd0; bus.burst_len = 16'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ne = 0; nv = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.err) ne++;
      if (bus.o_valid) nv++;
    end
    check("tmo_early_err", 32'(ne), 32'd0);
    tick();
    check("tmo_err", 32'(bus.err), 32'd1);
    check("tmo_busy_arm", 32'(bus.busy), 32'd1);
    tick();
    check("tmo_err_pulse", 32'(bus.err), 32'd0);
    check("tmo_idle", 32'(bus.busy), 32'd0);
    check("tmo_no_valid", 32'(nv), 32'd0);

    // stop on the third RUN cycle
    bus.mode = 2'd0; bus.burst_len = 16'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    nv = 0; nd = 0; last_data = 8'h00;
    for (int i = 0; i < 13; i++) begin
      bus.stop = (i == 2);
      tick();
      if (bus.o_valid) begin nv++; last_data = bus.o_data; end
      if (bus.done) nd++;
      if (i == 3) check("stop_idle_next", 32'(bus.busy), 32'd0);
    end
    bus.stop = 1'b0;
    check("stop_words", 32'(nv), 32'd3);
    check("stop_last_word", 32'(last_data), 32'h02);
    check("stop_no_done", 32'(nd), 32'd0);

    // stop and sync rise in the same ARM cycle: stop wins
    bus.burst_len = 16'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.stop = 1'b1; bus.sync_in = 1'b1;
    tick();
    bus.stop = 1'b0; bus.sync_in = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_valid) nv++;
    end
    check("stop_sync_no_words", 32'(nv), 32'd0);
    check("stop_sync_idle", 32'(bus.busy), 32'd0);

    // reset in the middle of a burst
    bus.burst_len = 16'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    tick();
    tick();
    check("rst_pre_valid", 32'(bus.o_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_data", 32'(bus.o_data), 32'h00);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    nv = 0; nd = 0; ne = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_valid) nv++;
      if (bus.done) nd++;
      if (bus.err) ne++;
    end
    check("rst_after_activity", 32'(nv + nd + ne), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
